// File: rtl/corelet_ctrl.sv
// Corelet sequencer: steps one tile pass through weight load, kernel load,
// activation load, execute, drain and readout, decoding the instruction word.
module corelet_ctrl #(
   parameter int row = 8,
   parameter int col = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   input  logic        acc_en,
   input  logic [7:0]  n_act,
   input  logic        l0_full,
   input  logic        ofifo_valid,
   output logic [34:0] inst,
   output logic        busy,
   output logic        done
);

   typedef enum logic [3:0] {
      IDLE, WLOAD, KLOAD, KWAIT, ALOAD, EXEC, DRAIN, RDOUT, DONE
   } state_e;

   localparam logic [7:0] COL_M1 = 8'(col - 1);
   localparam logic [7:0] ROW_M1 = 8'(row - 1);

   state_e     state_q;
   logic [7:0] cnt_q;
   logic       mode_q;
   logic       acc_q;
   logic [7:0] nact_q;
   logic [7:0] nact_m1;

   assign nact_m1 = nact_q - 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         acc_q   <= 1'b0;
         nact_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (start && n_act != 8'd0) begin
               mode_q  <= mode;
               acc_q   <= acc_en;
               nact_q  <= n_act;
               cnt_q   <= '0;
               state_q <= WLOAD;
            end
            WLOAD: if (!l0_full) begin
               if (cnt_q == COL_M1) begin
                  cnt_q   <= '0;
                  state_q <= KLOAD;
               end else cnt_q <= cnt_q + 8'd1;
            end
            KLOAD: if (cnt_q == COL_M1) begin
               cnt_q   <= '0;
               state_q <= KWAIT;
            end else cnt_q <= cnt_q + 8'd1;
            KWAIT: if (cnt_q == ROW_M1) begin
               cnt_q   <= '0;
               state_q <= ALOAD;
            end else cnt_q <= cnt_q + 8'd1;
            ALOAD: if (!l0_full) begin
               if (cnt_q == nact_m1) begin
                  cnt_q   <= '0;
                  state_q <= EXEC;
               end else cnt_q <= cnt_q + 8'd1;
            end
            EXEC: if (cnt_q == nact_m1) begin
               cnt_q   <= '0;
               state_q <= DRAIN;
            end else cnt_q <= cnt_q + 8'd1;
            // Drain waits indefinitely for the first complete output row.
            DRAIN: if (ofifo_valid) begin
               cnt_q   <= '0;
               state_q <= RDOUT;
            end
            RDOUT: if (ofifo_valid) begin
               if (cnt_q == nact_m1) begin
                  cnt_q   <= '0;
                  state_q <= DONE;
               end else cnt_q <= cnt_q + 8'd1;
            end
            DONE: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      inst = '0;
      busy = (state_q != IDLE);
      done = (state_q == DONE);
      if (busy) inst[34] = mode_q;
      case (state_q)
         WLOAD: begin
            if (mode_q) inst[4] = !l0_full;
            else        inst[2] = !l0_full;
         end
         KLOAD: begin
            if (mode_q) inst[5] = 1'b1;
            else begin
               inst[3] = 1'b1;
               inst[0] = 1'b1;
            end
         end
         ALOAD: inst[2] = !l0_full;
         EXEC: begin
            inst[3] = 1'b1;
            inst[1] = 1'b1;
         end
         RDOUT: begin
            inst[6]  = ofifo_valid;
            inst[33] = ofifo_valid & acc_q;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/corelet_ctrl.md
CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameters: row, default 8, number of PE rows and L0 lanes; col, default 8, number of PE columns.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a single-cycle request to run one tile pass.
REQ-005 SHALL have port mode, input, 1, 0=WS and 1=OS, sampled on an accepted start.
REQ-006 SHALL have port acc_en, input, 1, the SFP accumulate enable during readout, sampled on an accepted start.
REQ-007 SHALL have port n_act, input, 8, the activation vector count for the pass, sampled on an accepted start.
REQ-008 SHALL have port l0_full, input, 1, L0 full flag (write backpressure).
REQ-009 SHALL have port ofifo_valid, input, 1, OFIFO has a complete output row.
REQ-010 SHALL have port inst, output, 35, the corelet instruction word.
REQ-011 SHALL have port busy, output, 1, high in every non-IDLE state.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at the end of a pass.

Function
REQ-013 SHALL use this inst map:
- [1:0] MAC inst: bit0 = kernel load, bit1 = execute
- [2] l0_wr; [3] l0_rd; [4] ififo_wr; [5] ififo_rd; [6] ofifo_rd
- [33] sfp_acc; [34] mode
- [32:7] reserved, always 0
REQ-014 SHALL implement states IDLE, WLOAD, KLOAD, KWAIT, ALOAD, EXEC, DRAIN, RDOUT, DONE, with one shared 8-bit counter cleared on every state entry.
REQ-015 SHALL in IDLE accept start only when n_act != 0, then latch mode, acc_en and n_act and go to WLOAD; start with n_act == 0 is ignored.
REQ-016 SHALL ignore start in every non-IDLE state.
REQ-017 SHALL in WLOAD drive the write request (WS: inst[2]; OS: inst[4]) as !l0_full, count only accepted writes, and go to KLOAD after col accepted writes.
REQ-018 SHALL in KLOAD drive for exactly col cycles WS: inst[3]=1 and inst[0]=1, or OS: inst[5]=1 with inst[1:0]=00; then go to KWAIT.
REQ-019 SHALL in KWAIT drive all control bits 0 for exactly row cycles, then go to ALOAD.
REQ-020 SHALL in ALOAD drive inst[2]=!l0_full, count accepted writes, and go to EXEC after n_act accepted writes.
REQ-021 SHALL in EXEC drive inst[3]=1 and inst[1]=1 for exactly n_act cycles, then go to DRAIN.
REQ-022 SHALL in DRAIN drive all control bits 0 and move to RDOUT on the first cycle in which ofifo_valid=1; there is no timeout.
REQ-023 SHALL in RDOUT drive inst[6]=ofifo_valid and inst[33]=ofifo_valid&acc_en, count accepted reads, and go to DONE after n_act reads.
REQ-024 SHALL in DONE assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 SHALL drive inst[34] equal to the latched mode in every non-IDLE state and 0 in IDLE.
REQ-026 SHALL drive inst as a combinational decode of state, counter, the latched configuration, l0_full and ofifo_valid, with no added latency; every bit not named for a state is 0.
REQ-027 SHALL make exactly one write request per cycle at most; when l0_full=1 the write bit is 0 and the counter holds.

Reset
REQ-028 SHALL on reset, at any time including mid-pass, immediately force state IDLE, counter 0, latched mode, acc_en and n_act 0, inst=0, busy=0, done=0.
REQ-029 SHALL be ready to accept start in the first clock edge after reset deasserts.

Verification
REQ-030 SHALL cover WS pass: mode=0, n_act=4, l0_full=0, ofifo_valid rising 3 cycles after EXEC ends -> inst[2] high 8 cycles, inst[3]&inst[0] 8, idle 8, inst[2] 4, inst[3]&inst[1] 4, inst[6] 4, done once; total cycles = 8+8+8+4+4+3+4+1.
REQ-031 SHALL cover OS pass: mode=1, n_act=2 -> inst[4] 8 cycles then inst[5] 8 cycles, inst[1:0]=00 in KLOAD, inst[34]=1 while busy.
REQ-032 SHALL cover backpressure: l0_full high for 5 cycles in mid-WLOAD -> write bit 0 during stall, exactly 8 accepted writes total, KLOAD entry delayed by 5 cycles.
REQ-033 SHALL cover readout gaps: ofifo_valid toggling 1,0,1,0 with n_act=2 and acc_en=1 -> inst[6]=inst[33] follow ofifo_valid, DONE reached after the 2nd accepted read.
REQ-034 SHALL cover illegal and late start: start with n_act=0 -> busy stays 0; start pulse during EXEC -> ignored, pass completes unchanged.
REQ-035 SHALL cover reset mid-EXEC: reset asserted -> inst=0 and busy=0 in the same cycle; a new start after release runs a full, correct pass.
